// File: rtl/minx16_scb_pkg.sv
// Shared types and constants for the Wishbone-to-SCB bridge.
package minx16_scb_pkg;

  localparam int unsigned SCB_A  = 11;
  localparam int unsigned SCB_D  = 16;
  localparam int unsigned SCB_B  = 2;
  localparam int unsigned WB_D   = 32;
  localparam int unsigned WB_S   = 4;
  localparam int unsigned WADR_W = SCB_A - 2;
  localparam int unsigned ST_W   = 3;

  localparam logic [WB_D-1:0] DEF_BASE_ADDR = 32'h3000_0000;
  localparam logic [WB_D-1:0] DEF_BASE_MASK = 32'hFFFF_F800;
  localparam logic [WB_D-1:0] TIMEOUT_DATA  = 32'hDEAD_DEAD;

  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LO     = 3'd1;
  localparam state_t ST_LO_CAP = 3'd2;
  localparam state_t ST_HI     = 3'd3;
  localparam state_t ST_HI_CAP = 3'd4;
  localparam state_t ST_ACK    = 3'd5;

  // Latched Wishbone request: word address within the window, lanes, data, direction.
  typedef struct packed {
    logic [WADR_W-1:0] wadr;
    logic [WB_S-1:0]   sel;
    logic [WB_D-1:0]   dat;
    logic              we;
  } wb_req_t;

  // Expand a 2-bit byte-lane select into a 16-bit data mask.
  function automatic logic [SCB_D-1:0] lane_mask(input logic [SCB_B-1:0] sel);
    return {{8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/scb_wb_bridge_if.sv
// Wishbone slave + SCB master signal bundle for scb_wb_bridge.
interface scb_wb_bridge_if;
  import minx16_scb_pkg::*;

  logic              wbs_cyc_i;
  logic              wbs_stb_i;
  logic              wbs_we_i;
  logic [WB_S-1:0]   wbs_sel_i;
  logic [WB_D-1:0]   wbs_adr_i;
  logic [WB_D-1:0]   wbs_dat_i;
  logic              wbs_ack_o;
  logic [WB_D-1:0]   wbs_dat_o;
  logic [SCB_A-1:0]  scb_Addr_o;
  logic [SCB_D-1:0]  scb_Data_o;
  logic [SCB_D-1:0]  scb_Data_i;
  logic [SCB_B-1:0]  scb_stb_o;
  logic              scb_ce_o;
  logic              scb_rd_o;
  logic              scb_wr_o;
  logic              scb_rdy_i;

  // Bridge view.
  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  scb_Data_i, scb_rdy_i,
    output wbs_ack_o, wbs_dat_o,
    output scb_Addr_o, scb_Data_o, scb_stb_o, scb_ce_o, scb_rd_o, scb_wr_o
  );

  // Host bus + scratchpad view.
  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output scb_Data_i, scb_rdy_i,
    input  wbs_ack_o, wbs_dat_o,
    input  scb_Addr_o, scb_Data_o, scb_stb_o, scb_ce_o, scb_rd_o, scb_wr_o
  );

endinterface

// File: rtl/scb_wb_bridge.sv
// Wishbone (32-bit) slave that splits each access into low/high 16-bit SCB accesses.
// Optional stall timeout: define SCB_BRIDGE_TIMEOUT_EN.
module scb_wb_bridge
  import minx16_scb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter logic [31:0] BASE_MASK = DEF_BASE_MASK,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  scb_wb_bridge_if.slave bus
);

  state_t           state, state_n;
  wb_req_t          req, req_n;
  logic [WB_D-1:0]  rbuf, rbuf_n;
  logic             aborted, aborted_n;

  logic             ack_q, ack_n;
  logic [WB_D-1:0]  dat_q, dat_n;
  logic [SCB_A-1:0] addr_q, addr_n;
  logic [SCB_D-1:0] data_q, data_n;
  logic [SCB_B-1:0] stb_q, stb_n;
  logic             ce_q, ce_n;
  logic             rd_q, rd_n;
  logic             wr_q, wr_n;

  logic             hit_c;
  logic             acc_c;
  logic             half_c;
  logic             expire_c;

  assign hit_c = bus.wbs_cyc_i & bus.wbs_stb_i &
                 ((bus.wbs_adr_i & BASE_MASK) == BASE_ADDR);

`ifdef SCB_BRIDGE_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] stall_cnt;
  logic             stall_c;

  assign stall_c  = ((state == ST_LO) || (state == ST_HI)) && !bus.scb_rdy_i;
  assign expire_c = stall_c && (stall_cnt == CNT_W'(TIMEOUT - 1));

  // Consecutive stall cycles in the current access state; restarts on any state change.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt <= '0;
    end else if (state_n != state) begin
      stall_cnt <= '0;
    end else if (stall_c) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_timeout;

  assign expire_c       = 1'b0;
  assign unused_timeout = (TIMEOUT == 32'd0);
`endif

  // Next state, request latch, read buffer and next values of the registered outputs.
  always_comb begin
    state_n   = state;
    req_n     = req;
    rbuf_n    = rbuf;
    aborted_n = aborted;
    acc_c     = 1'b0;
    half_c    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (hit_c) begin
          req_n.wadr = bus.wbs_adr_i[SCB_A-1:2];
          req_n.sel  = bus.wbs_sel_i;
          req_n.dat  = bus.wbs_dat_i;
          req_n.we   = bus.wbs_we_i;
          rbuf_n     = '0;
          aborted_n  = 1'b0;
          if (|bus.wbs_sel_i[1:0]) begin
            state_n = ST_LO;
          end else if (|bus.wbs_sel_i[3:2]) begin
            state_n = ST_HI;
          end else begin
            state_n = ST_ACK;
          end
        end
      end
      ST_LO: begin
        if (bus.scb_rdy_i) begin
          if (req.we) begin
            state_n = (|req.sel[3:2]) ? ST_HI : ST_ACK;
          end else begin
            state_n = ST_LO_CAP;
          end
        end else if (expire_c) begin
          state_n = ST_ACK;
          rbuf_n  = TIMEOUT_DATA;
        end
      end
      ST_HI: begin
        if (bus.scb_rdy_i) begin
          state_n = req.we ? ST_ACK : ST_HI_CAP;
        end else if (expire_c) begin
          state_n = ST_ACK;
          rbuf_n  = TIMEOUT_DATA;
        end
      end
      ST_LO_CAP: begin
        rbuf_n[15:0] = bus.scb_Data_i & lane_mask(req.sel[1:0]);
        state_n      = (|req.sel[3:2]) ? ST_HI : ST_ACK;
      end
      ST_HI_CAP: begin
        rbuf_n[31:16] = bus.scb_Data_i & lane_mask(req.sel[3:2]);
        state_n       = ST_ACK;
      end
      ST_ACK: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    // Host gave up mid-transaction: finish SCB work, but never acknowledge.
    if ((state != ST_IDLE) && !bus.wbs_cyc_i) begin
      aborted_n = 1'b1;
    end

    acc_c  = (state_n == ST_LO) || (state_n == ST_HI);
    half_c = (state_n == ST_HI);

    ce_n   = acc_c;
    rd_n   = acc_c & ~req_n.we;
    wr_n   = acc_c & req_n.we;
    stb_n  = acc_c ? (half_c ? req_n.sel[3:2] : req_n.sel[1:0]) : '0;
    addr_n = acc_c ? {req_n.wadr, half_c, 1'b0} : addr_q;
    data_n = acc_c ? (half_c ? req_n.dat[31:16] : req_n.dat[15:0]) : data_q;
    ack_n  = (state_n == ST_ACK) & bus.wbs_cyc_i & ~aborted_n;
    dat_n  = (state_n == ST_ACK) ? rbuf_n : dat_q;
  end

  // State, request and registered bus outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= ST_IDLE;
      req     <= '0;
      rbuf    <= '0;
      aborted <= 1'b0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      stb_q   <= '0;
      ce_q    <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state   <= state_n;
      req     <= req_n;
      rbuf    <= rbuf_n;
      aborted <= aborted_n;
      ack_q   <= ack_n;
      dat_q   <= dat_n;
      addr_q  <= addr_n;
      data_q  <= data_n;
      stb_q   <= stb_n;
      ce_q    <= ce_n;
      rd_q    <= rd_n;
      wr_q    <= wr_n;
    end
  end

  assign bus.wbs_ack_o  = ack_q;
  assign bus.wbs_dat_o  = dat_q;
  assign bus.scb_Addr_o = addr_q;
  assign bus.scb_Data_o = data_q;
  assign bus.scb_stb_o  = stb_q;
  assign bus.scb_ce_o   = ce_q;
  assign bus.scb_rd_o   = rd_q;
  assign bus.scb_wr_o   = wr_q;

endmodule

// File: tb/tb_scb_wb_bridge.sv
// Directed bench for scb_wb_bridge with a byte-lane SCB scratchpad model.
module tb_scb_wb_bridge;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] mem [0:1023];

  scb_wb_bridge_if bus ();

  scb_wb_bridge #(
    .BASE_ADDR (32'h3000_0000),
    .BASE_MASK (32'hFFFF_F800),
    .TIMEOUT   (16)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Scratchpad: one-cycle read latency, byte-strobed writes, cleared while in reset.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
      bus.scb_Data_i <= '0;
    end else if (bus.scb_ce_o && bus.scb_rdy_i) begin
      if (bus.scb_wr_o) begin
        if (bus.scb_stb_o[0]) mem[bus.scb_Addr_o[10:1]][7:0]  <= bus.scb_Data_o[7:0];
        if (bus.scb_stb_o[1]) mem[bus.scb_Addr_o[10:1]][15:8] <= bus.scb_Data_o[15:8];
      end
      if (bus.scb_rd_o) bus.scb_Data_i <= mem[bus.scb_Addr_o[10:1]];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // {ce, rd, wr, stb, Addr, Data}
  function automatic logic [31:0] snap();
    return {bus.scb_ce_o, bus.scb_rd_o, bus.scb_wr_o, bus.scb_stb_o,
            bus.scb_Addr_o, bus.scb_Data_o};
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wb_req(input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic we);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = dat;
    bus.wbs_sel_i = sel;
    bus.wbs_we_i  = we;
  endtask

  task automatic wb_idle();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;
    bus.wbs_sel_i = '0;
    bus.wbs_we_i  = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (bus.wbs_ack_o !== 1'b0 || bus.wbs_dat_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_wb got ack=%b dat=%h want ack=0 dat=0", bus.wbs_ack_o, bus.wbs_dat_o);
    end
    checks++;
    if (snap() !== 32'h0) begin
      errors++;
      $display("FAIL reset_scb got %h want 00000000", snap());
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_full_write();
    logic [31:0] e;
    wb_req(32'h3000_0010, 32'hA1B2_C3D4, 4'hF, 1'b1);
    checks++;
    if (snap() !== 32'h0 || bus.wbs_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL fw_c0 got scb=%h ack=%b want scb=00000000 ack=0", snap(), bus.wbs_ack_o);
    end
    step();
    e = {1'b1, 1'b0, 1'b1, 2'b11, 11'h010, 16'hC3D4};
    checks++;
    if (snap() !== e || bus.wbs_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL fw_c1 got scb=%h ack=%b want scb=%h ack=0", snap(), bus.wbs_ack_o, e);
    end
    step();
    e = {1'b1, 1'b0, 1'b1, 2'b11, 11'h012, 16'hA1B2};
    checks++;
    if (snap() !== e || bus.wbs_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL fw_c2 got scb=%h ack=%b want scb=%h ack=0", snap(), bus.wbs_ack_o, e);
    end
    step();
    e = {1'b0, 1'b0, 1'b0, 2'b00, 11'h012, 16'hA1B2};
    checks++;
    if (snap() !== e || bus.wbs_ack_o !== 1'b1) begin
      errors++;
      $display("FAIL fw_c3 got scb=%h ack=%b want scb=%h ack=1", snap(), bus.wbs_ack_o, e);
    end
    wb_idle();
    step();
    checks++;
    if (bus.wbs_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL fw_c4_ack got %b want 0", bus.wbs_ack_o);
    end
  endtask

  task automatic test_full_read();
    logic [31:0] e;
    wb_req(32'h3000_0010, 32'h0, 4'hF, 1'b0);
    step();
    e = {1'b1, 1'b1, 1'b0, 2'b11, 11'h010, 16'h0000};
    checks++;
    if (snap() !== e) begin
      errors++;
      $display("FAIL fr_c1 got %h want %h", snap(), e);
    end
    step();
    e = {1'b0, 1'b0, 1'b0, 2'b00, 11'h010, 16'h0000};
    checks++;
    if (snap() !== e || bus.wbs_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL fr_c2 got scb=%h ack=%b want scb=%h ack=0", snap(), bus.wbs_ack_o, e);
    end
    step();
    e = {1'b1, 1'b1, 1'b0, 2'b11, 11'h012, 16'h0000};
    checks++;
    if (snap() !== e) begin
      errors++;
      $display("FAIL fr_c3 got %h want %h", snap(), e);
    end
    step();
    checks++;
    if (bus.wbs_ack_o !== 1'b0 || bus.scb_ce_o !== 1'b0) begin
      errors++;
      $display("FAIL fr_c4 got ack=%b ce=%b want 0 0", bus.wbs_ack_o, bus.scb_ce_o);
    end
    step();
    checks++;
    if (bus.wbs_ack_o !== 1'b1 || bus.wbs_dat_o !== 32'hA1B2_C3D4) begin
      errors++;
      $display("FAIL fr_c5 got ack=%b dat=%h want ack=1 dat=a1b2c3d4", bus.wbs_ack_o, bus.wbs_dat_o);
    end
    wb_idle();
    step();
  endtask

  task automatic test_single_half();
    logic [31:0] e;
    wb_req(32'h3000_07FC, 32'h00EE_0000, 4'b0100, 1'b1);
    step();
    e = {1'b1, 1'b0, 1'b1, 2'b01, 11'h7FE, 16'h00EE};
    checks++;
    if (snap() !== e || bus.wbs_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL sh_wr_c1 got scb=%h ack=%b want scb=%h ack=0", snap(), bus.wbs_ack_o, e);
    end
    step();
    checks++;
    if (bus.wbs_ack_o !== 1'b1 || bus.scb_ce_o !== 1'b0) begin
      errors++;
      $display("FAIL sh_wr_c2 got ack=%b ce=%b want ack=1 ce=0", bus.wbs_ack_o, bus.scb_ce_o);
    end
    wb_idle();
    step();
    wb_req(32'h3000_07FC, 32'h0, 4'b0100, 1'b0);
    step();
    e = {1'b1, 1'b1, 1'b0, 2'b01, 11'h7FE, 16'h0000};
    checks++;
    if (snap() !== e) begin
      errors++;
      $display("FAIL sh_rd_c1 got %h want %h", snap(), e);
    end
    step();
    checks++;
    if (bus.wbs_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL sh_rd_c2_ack got %b want 0", bus.wbs_ack_o);
    end
    step();
    checks++;
    if (bus.wbs_ack_o !== 1'b1 || bus.wbs_dat_o !== 32'h00EE_0000) begin
      errors++;
      $display("FAIL sh_rd_c3 got ack=%b dat=%h want ack=1 dat=00ee0000", bus.wbs_ack_o, bus.wbs_dat_o);
    end
    wb_idle();
    step();
  endtask

  task automatic test_lane_mask();
    wb_req(32'h3000_0010, 32'h0, 4'b0110, 1'b0);
    step(4);
    checks++;
    if (bus.wbs_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL lm_c4_ack got %b want 0", bus.wbs_ack_o);
    end
    step();
    checks++;
    if (bus.wbs_ack_o !== 1'b1 || bus.wbs_dat_o !== 32'h00B2_C300) begin
      errors++;
      $display("FAIL lm_c5 got ack=%b dat=%h want ack=1 dat=00b2c300", bus.wbs_ack_o, bus.wbs_dat_o);
    end
    wb_idle();
    step();
  endtask

  task automatic test_sel_zero();
    wb_req(32'h3000_0010, 32'h0, 4'h0, 1'b0);
    step();
    checks++;
    if (bus.wbs_ack_o !== 1'b1 || bus.wbs_dat_o !== 32'h0 || bus.scb_ce_o !== 1'b0) begin
      errors++;
      $display("FAIL sel0_c1 got ack=%b dat=%h ce=%b want ack=1 dat=0 ce=0",
               bus.wbs_ack_o, bus.wbs_dat_o, bus.scb_ce_o);
    end
    wb_idle();
    step();
    checks++;
    if (bus.wbs_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL sel0_c2_ack got %b want 0", bus.wbs_ack_o);
    end
  endtask

  task automatic test_stall();
    logic [31:0] e;
    e = {1'b1, 1'b1, 1'b0, 2'b11, 11'h010, 16'h0000};
    bus.scb_rdy_i = 1'b0;
    wb_req(32'h3000_0010, 32'h0, 4'hF, 1'b0);
    step();
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) bus.scb_rdy_i = 1'b1;
      checks++;
      if (snap() !== e || bus.wbs_ack_o !== 1'b0) begin
        errors++;
        $display("FAIL stall_c%0d got scb=%h ack=%b want scb=%h ack=0", k, snap(), bus.wbs_ack_o, e);
      end
      step();
    end
    step(2);
    checks++;
    if (bus.wbs_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL stall_c7_ack got %b want 0", bus.wbs_ack_o);
    end
    step();
    checks++;
    if (bus.wbs_ack_o !== 1'b1 || bus.wbs_dat_o !== 32'hA1B2_C3D4) begin
      errors++;
      $display("FAIL stall_c8 got ack=%b dat=%h want ack=1 dat=a1b2c3d4", bus.wbs_ack_o, bus.wbs_dat_o);
    end
    wb_idle();
    step();
  endtask

  task automatic test_miss();
    wb_req(32'h3000_1000, 32'h0, 4'hF, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (bus.wbs_ack_o !== 1'b0 || bus.scb_ce_o !== 1'b0) begin
        errors++;
        $display("FAIL miss_c%0d got ack=%b ce=%b want 0 0", k + 1, bus.wbs_ack_o, bus.scb_ce_o);
      end
    end
    wb_idle();
    step();
  endtask

  task automatic test_reset_midway();
    logic [31:0] e;
    wb_req(32'h3000_0020, 32'h1122_3344, 4'hF, 1'b1);
    step(2);
    e = {1'b1, 1'b0, 1'b1, 2'b11, 11'h022, 16'h1122};
    checks++;
    if (snap() !== e) begin
      errors++;
      $display("FAIL rstm_hi got %h want %h", snap(), e);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (snap() !== 32'h0 || bus.wbs_ack_o !== 1'b0 || bus.wbs_dat_o !== 32'h0) begin
      errors++;
      $display("FAIL rstm_clear got scb=%h ack=%b dat=%h want all 0",
               snap(), bus.wbs_ack_o, bus.wbs_dat_o);
    end
    wb_idle();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    wb_req(32'h3000_0020, 32'h0, 4'hF, 1'b0);
    step(4);
    checks++;
    if (bus.wbs_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL rstm_rd_c4_ack got %b want 0", bus.wbs_ack_o);
    end
    step();
    checks++;
    if (bus.wbs_ack_o !== 1'b1 || bus.wbs_dat_o !== 32'h0000_3344) begin
      errors++;
      $display("FAIL rstm_rd_c5 got ack=%b dat=%h want ack=1 dat=00003344", bus.wbs_ack_o, bus.wbs_dat_o);
    end
    wb_idle();
    step();
  endtask

  task automatic test_cyc_drop();
    logic [31:0] e;
    wb_req(32'h3000_0030, 32'hCAFE_F00D, 4'hF, 1'b1);
    step();
    e = {1'b1, 1'b0, 1'b1, 2'b11, 11'h030, 16'hF00D};
    checks++;
    if (snap() !== e) begin
      errors++;
      $display("FAIL drop_c1 got %h want %h", snap(), e);
    end
    wb_idle();
    step();
    e = {1'b1, 1'b0, 1'b1, 2'b11, 11'h032, 16'hCAFE};
    checks++;
    if (snap() !== e) begin
      errors++;
      $display("FAIL drop_c2 got %h want %h", snap(), e);
    end
    for (int k = 3; k <= 4; k++) begin
      step();
      checks++;
      if (bus.wbs_ack_o !== 1'b0 || bus.scb_ce_o !== 1'b0) begin
        errors++;
        $display("FAIL drop_c%0d got ack=%b ce=%b want 0 0", k, bus.wbs_ack_o, bus.scb_ce_o);
      end
    end
    wb_req(32'h3000_0030, 32'h0, 4'hF, 1'b0);
    step(5);
    checks++;
    if (bus.wbs_ack_o !== 1'b1 || bus.wbs_dat_o !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL drop_rd got ack=%b dat=%h want ack=1 dat=cafef00d", bus.wbs_ack_o, bus.wbs_dat_o);
    end
    wb_idle();
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    wb_req(32'h3000_0040, 32'h55AA_55AA, 4'b0011, 1'b1);
    step(2);
    checks++;
    if (bus.wbs_ack_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_wr_ack got %b want 1", bus.wbs_ack_o);
    end
    wb_req(32'h3000_0040, 32'h0, 4'b0011, 1'b0);
    step();
    checks++;
    if (bus.wbs_ack_o !== 1'b0 || bus.scb_ce_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle got ack=%b ce=%b want 0 0", bus.wbs_ack_o, bus.scb_ce_o);
    end
    step();
    e = {1'b1, 1'b1, 1'b0, 2'b11, 11'h040, 16'h0000};
    checks++;
    if (snap() !== e) begin
      errors++;
      $display("FAIL b2b_rd_lo got %h want %h", snap(), e);
    end
    step(2);
    checks++;
    if (bus.wbs_ack_o !== 1'b1 || bus.wbs_dat_o !== 32'h0000_55AA) begin
      errors++;
      $display("FAIL b2b_rd got ack=%b dat=%h want ack=1 dat=000055aa", bus.wbs_ack_o, bus.wbs_dat_o);
    end
    wb_idle();
    step();
  endtask

`ifdef SCB_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    bus.scb_rdy_i = 1'b0;
    wb_req(32'h3000_0050, 32'h1234_5678, 4'hF, 1'b1);
    step(16);
    checks++;
    if (bus.scb_ce_o !== 1'b1 || bus.wbs_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL tmo_c16 got ce=%b ack=%b want ce=1 ack=0", bus.scb_ce_o, bus.wbs_ack_o);
    end
    step();
    checks++;
    if (bus.wbs_ack_o !== 1'b1 || bus.wbs_dat_o !== 32'hDEAD_DEAD || bus.scb_ce_o !== 1'b0) begin
      errors++;
      $display("FAIL tmo_c17 got ack=%b dat=%h ce=%b want ack=1 dat=deaddead ce=0",
               bus.wbs_ack_o, bus.wbs_dat_o, bus.scb_ce_o);
    end
    bus.scb_rdy_i = 1'b1;
    wb_idle();
    step();
  endtask
`else
  task automatic test_timeout();
    bus.scb_rdy_i = 1'b0;
    wb_req(32'h3000_0050, 32'h1234_5678, 4'hF, 1'b1);
    step(20);
    checks++;
    if (bus.scb_ce_o !== 1'b1 || bus.wbs_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL nostall_c20 got ce=%b ack=%b want ce=1 ack=0", bus.scb_ce_o, bus.wbs_ack_o);
    end
    bus.scb_rdy_i = 1'b1;
    step(2);
    checks++;
    if (bus.wbs_ack_o !== 1'b1) begin
      errors++;
      $display("FAIL nostall_ack got %b want 1", bus.wbs_ack_o);
    end
    wb_idle();
    step();
  endtask
`endif

  initial begin
    wb_idle();
    bus.scb_rdy_i = 1'b1;
    test_reset();
    test_full_write();
    test_full_read();
    test_single_half();
    test_lane_mask();
    test_sel_zero();
    test_stall();
    test_miss();
    test_reset_midway();
    test_cyc_drop();
    test_back_to_back();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
